cell_painter: RTL and testbench

Pixel-level draw engine directly downstream of the game-logic handshake block. It consumes the draw and erase requests, together with the 5-bit maze-cell coordinates of the player's new and previous positions. It rasterises one square cell into VGA adapter plot writes, then completes a four-phase handshake back to the position controller through `doneDraw` and `doneErase`.

---
 rtl/cell_painter.sv | 162 ++++++++++++++++
 tb/tb_cell_painter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cell_painter.sv
// Rasterises one square maze cell into VGA plot writes, then holds a
// four-phase done handshake until the originating request drops.
module cell_painter #(
  parameter int         CELL_LOG2     = 2,
  parameter int         GRID_W        = 32,
  parameter int         GRID_H        = 30,
  parameter logic [2:0] PLAYER_COLOUR = 3'b100,
  parameter logic [2:0] PATH_COLOUR   = 3'b111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       drawBox,
  input  logic       eraseBox,
  input  logic [4:0] drawX,
  input  logic [4:0] drawY,
  input  logic [4:0] prevX,
  input  logic [4:0] prevY,
  output logic       plot,
  output logic [7:0] vgaX,
  output logic [6:0] vgaY,
  output logic [2:0] colour,
  output logic       doneDraw,
  output logic       doneErase,
  output logic       busy
);

  localparam int CNT_W = 2 * CELL_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_PLOT, S_DONE} state_e;
  typedef enum logic       {OP_DRAW, OP_ERASE}      op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [4:0]       cell_x_q, cell_x_d, cell_y_q, cell_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             plot_q, plot_d;
  logic [7:0]       vga_x_q, vga_x_d;
  logic [6:0]       vga_y_q, vga_y_d;
  logic [2:0]       colour_q, colour_d;
  logic             done_draw_q, done_draw_d;
  logic             done_erase_q, done_erase_d;

  op_e              req_op;
  logic [4:0]       req_x, req_y;
  logic [CNT_W-1:0] cnt_nx;
  logic             req_live;

  // Pixel address is a pure concatenation: cell index above, scan offset below.
  function automatic logic [7:0] pix_x(input logic [4:0] cx, input logic [CNT_W-1:0] c);
    return 8'({cx, c[CELL_LOG2-1:0]});
  endfunction

  function automatic logic [6:0] pix_y(input logic [4:0] cy, input logic [CNT_W-1:0] c);
    return 7'({cy, c[CNT_W-1:CELL_LOG2]});
  endfunction

  function automatic logic [2:0] op_colour(input op_e op);
    return (op == OP_ERASE) ? PATH_COLOUR : PLAYER_COLOUR;
  endfunction

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cell_x_d     = cell_x_q;
    cell_y_d     = cell_y_q;
    cnt_d        = cnt_q;
    plot_d       = 1'b0;
    vga_x_d      = '0;
    vga_y_d      = '0;
    colour_d     = '0;
    done_draw_d  = 1'b0;
    done_erase_d = 1'b0;
    req_op       = eraseBox ? OP_ERASE : OP_DRAW;
    req_x        = eraseBox ? prevX : drawX;
    req_y        = eraseBox ? prevY : drawY;
    cnt_nx       = cnt_q + CNT_W'(1);
    req_live     = (op_q == OP_ERASE) ? eraseBox : drawBox;

    unique case (state_q)
      S_IDLE: begin
        if (eraseBox || drawBox) begin
          op_d     = req_op;
          cell_x_d = req_x;
          cell_y_d = req_y;
          cnt_d    = '0;
          if ({27'd0, req_x} >= 32'(GRID_W) || {27'd0, req_y} >= 32'(GRID_H)) begin
            // Off-grid cells skip plotting but still complete the handshake.
            state_d      = S_DONE;
            done_erase_d = (req_op == OP_ERASE);
            done_draw_d  = (req_op == OP_DRAW);
          end else begin
            state_d  = S_PLOT;
            plot_d   = 1'b1;
            vga_x_d  = pix_x(req_x, '0);
            vga_y_d  = pix_y(req_y, '0);
            colour_d = op_colour(req_op);
          end
        end
      end
      S_PLOT: begin
        // cnt_q is the pixel currently on the outputs.
        if (cnt_q == '1) begin
          state_d      = S_DONE;
          done_erase_d = (op_q == OP_ERASE);
          done_draw_d  = (op_q == OP_DRAW);
        end else begin
          cnt_d    = cnt_nx;
          plot_d   = 1'b1;
          vga_x_d  = pix_x(cell_x_q, cnt_nx);
          vga_y_d  = pix_y(cell_y_q, cnt_nx);
          colour_d = op_colour(op_q);
        end
      end
      S_DONE: begin
        if (req_live) begin
          done_erase_d = (op_q == OP_ERASE);
          done_draw_d  = (op_q == OP_DRAW);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_DRAW;
      cell_x_q     <= '0;
      cell_y_q     <= '0;
      cnt_q        <= '0;
      plot_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      colour_q     <= '0;
      done_draw_q  <= 1'b0;
      done_erase_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cell_x_q     <= cell_x_d;
      cell_y_q     <= cell_y_d;
      cnt_q        <= cnt_d;
      plot_q       <= plot_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      colour_q     <= colour_d;
      done_draw_q  <= done_draw_d;
      done_erase_q <= done_erase_d;
    end
  end

  assign plot      = plot_q;
  assign vgaX      = vga_x_q;
  assign vgaY      = vga_y_q;
  assign colour    = colour_q;
  assign doneDraw  = done_draw_q;
  assign doneErase = done_erase_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cell_painter.sv
// Bench for cell_painter: table of cell requests, hand-written handshake corner
// cases, and random requests checked against pixel lists built arithmetically.
module tb_cell_painter;

  logic       clock = 1'b0;
  logic       reset;
  logic       drawBox, eraseBox;
  logic [4:0] drawX, drawY, prevX, prevY;
  logic       plot;
  logic [7:0] vgaX;
  logic [6:0] vgaY;
  logic [2:0] colour;
  logic       doneDraw, doneErase, busy;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  cell_painter dut (
    .clock(clock), .reset(reset),
    .drawBox(drawBox), .eraseBox(eraseBox),
    .drawX(drawX), .drawY(drawY), .prevX(prevX), .prevY(prevY),
    .plot(plot), .vgaX(vgaX), .vgaY(vgaY), .colour(colour),
    .doneDraw(doneDraw), .doneErase(doneErase), .busy(busy)
  );

  typedef struct {
    bit         er;
    logic [4:0] x, y;
    int         fx, fy, n;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expect n row-major pixels of a 4x4 cell starting at (fx,fy), then the done cycle.
  // At plot index mut the served request's coordinates are overwritten with mx.
  task automatic burst(input bit er, input int fx, input int fy, input int n,
                       input int mut, input logic [4:0] mx);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("plot", plot, 1);
      chk("vgaX", vgaX, fx + i % 4);
      chk("vgaY", vgaY, fy + i / 4);
      chk("colour", colour, er ? 7 : 4);
      chk("busy_plot", busy, 1);
      if (i == mut) begin
        if (er) begin prevX = mx; prevY = mx; end
        else    begin drawX = mx; drawY = mx; end
      end
    end
    @(negedge clock);
    chk("plot_after", plot, 0);
    chk("doneErase_rise", doneErase, er);
    chk("doneDraw_rise", doneDraw, !er);
    chk("busy_done", busy, 1);
  endtask

  task automatic hold(input bit er, input int n);
    repeat (n) begin
      @(negedge clock);
      chk("plot_hold", plot, 0);
      chk("done_hold", er ? doneErase : doneDraw, 1);
      chk("busy_hold", busy, 1);
    end
  endtask

  task automatic drop(input bit er);
    if (er) eraseBox = 1'b0; else drawBox = 1'b0;
    @(negedge clock);
    chk("done_fall", er ? doneErase : doneDraw, 0);
    chk("busy_fall", busy, 0);
    chk("plot_idle", plot, 0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 5'd3,  5'd5,  12,  20,  16};
    vecs[1] = '{1'b1, 5'd0,  5'd0,  0,   0,   16};
    vecs[2] = '{1'b0, 5'd31, 5'd29, 124, 116, 16};
    vecs[3] = '{1'b1, 5'd31, 5'd29, 124, 116, 16};
    vecs[4] = '{1'b0, 5'd0,  5'd30, 0,   0,   0};
    vecs[5] = '{1'b1, 5'd31, 5'd0,  124, 0,   16};
    vecs[6] = '{1'b0, 5'd5,  5'd31, 0,   0,   0};
    vecs[7] = '{1'b1, 5'd12, 5'd7,  48,  28,  16};

    reset = 1'b1; drawBox = 1'b0; eraseBox = 1'b0;
    drawX = '0; drawY = '0; prevX = '0; prevY = '0;
    repeat (2) @(negedge clock);
    chk("rst_plot", plot, 0);
    chk("rst_vgaX", vgaX, 0);
    chk("rst_vgaY", vgaY, 0);
    chk("rst_colour", colour, 0);
    chk("rst_doneDraw", doneDraw, 0);
    chk("rst_doneErase", doneErase, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);

    foreach (vecs[k]) begin
      if (vecs[k].er) begin
        prevX = vecs[k].x; prevY = vecs[k].y; drawX = 5'($urandom); drawY = 5'($urandom);
        eraseBox = 1'b1;
      end else begin
        drawX = vecs[k].x; drawY = vecs[k].y; prevX = 5'($urandom); prevY = 5'($urandom);
        drawBox = 1'b1;
      end
      burst(vecs[k].er, vecs[k].fx, vecs[k].fy, vecs[k].n, -1, 5'd0);
      hold(vecs[k].er, 2);
      drop(vecs[k].er);
    end

    // Erase wins when both are raised; draw follows once erase is released.
    prevX = 5'd1; prevY = 5'd0; drawX = 5'd2; drawY = 5'd0;
    eraseBox = 1'b1; drawBox = 1'b1;
    burst(1'b1, 4, 0, 16, -1, 5'd0);
    hold(1'b1, 1);
    drop(1'b1);
    burst(1'b0, 8, 0, 16, -1, 5'd0);
    drop(1'b0);

    // Held request gives exactly one burst.
    drawX = 5'd3; drawY = 5'd5; drawBox = 1'b1;
    burst(1'b0, 12, 20, 16, -1, 5'd0);
    hold(1'b0, 50);
    drop(1'b0);

    // Reset on the 6th plot cycle.
    drawX = 5'd3; drawY = 5'd5; drawBox = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("pre_reset_plot", plot, 1);
    end
    reset = 1'b1; drawBox = 1'b0;
    @(negedge clock);
    chk("abort_plot", plot, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", doneDraw, 0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("post_reset_plot", plot, 0);
      chk("post_reset_done", doneDraw, 0);
    end
    drawX = 5'd7; drawY = 5'd2; drawBox = 1'b1;
    burst(1'b0, 28, 8, 16, -1, 5'd0);
    drop(1'b0);

    // Coordinate change mid-burst is ignored.
    drawX = 5'd3; drawY = 5'd5; drawBox = 1'b1;
    burst(1'b0, 12, 20, 16, 3, 5'd9);
    drop(1'b0);

    // Random requests against an arithmetic pixel model.
    repeat (25) begin
      bit         both, er;
      logic [4:0] x, y, dx, dy;
      both = ($urandom_range(0, 3) == 0);
      er   = both ? 1'b1 : 1'($urandom_range(0, 1));
      x    = 5'($urandom_range(0, 31));
      y    = 5'($urandom_range(0, 31));
      dx   = 5'($urandom_range(0, 31));
      dy   = 5'($urandom_range(0, 31));
      if (er) begin prevX = x; prevY = y; eraseBox = 1'b1; end
      else    begin drawX = x; drawY = y; drawBox = 1'b1; end
      if (both) begin drawX = dx; drawY = dy; drawBox = 1'b1; end
      burst(er, int'(x) * 4, int'(y) * 4, (y < 30) ? 16 : 0,
            $urandom_range(0, 15), 5'($urandom));
      hold(er, $urandom_range(0, 4));
      drop(er);
      if (both) begin
        burst(1'b0, int'(dx) * 4, int'(dy) * 4, (dy < 30) ? 16 : 0, -1, 5'd0);
        hold(1'b0, $urandom_range(0, 3));
        drop(1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
